// File: rtl/ssd_mux_driver.sv
// ssd_mux_driver: binary-to-BCD (sequential double dabble) plus a time-multiplexed
// common-anode seven-segment driver for NUM_DIGITS digits.
// Optional build macro: SSD_BLANK_EN enables leading-zero blanking.
module ssd_mux_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int DATA_W      = 13,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     value,
  input  logic                  load,
  output logic                  busy,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            seg
);

  // Scratch keeps one spare nibble so an overflowing value cannot disturb the low digits.
  localparam int SCR_W = (NUM_DIGITS + 1) * 4;
  localparam int DSP_W = NUM_DIGITS * 4;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

  state_t                  r_state;
  logic                    r_busy;
  logic                    r_ovf;
  logic                    r_pend;
  logic [DATA_W-1:0]       r_pend_val;
  logic [DATA_W-1:0]       r_bin;
  logic [DATA_W-1:0]       r_cap;
  logic [SCR_W-1:0]        r_scr;
  logic [CNT_W-1:0]        r_cnt;
  logic [DSP_W-1:0]        r_disp;
  logic [REF_W-1:0]        r_ref;
  logic [IDX_W-1:0]        r_idx;
  logic [NUM_DIGITS-1:0]   r_anode;
  logic [6:0]              r_seg;

  logic [SCR_W-1:0]        w_adj;
  logic                    w_next_go;
  logic [DATA_W-1:0]       w_next_val;
  logic [3:0]              w_nib;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic [NUM_DIGITS-1:0]   w_blank_bus;
  logic                    w_blank_sel;
  logic [6:0]              w_seg;

  // A load arriving in COMMIT chains directly, and takes precedence over the stored pending value.
  assign w_next_go  = load | r_pend;
  assign w_next_val = load ? value : r_pend_val;

  // Double-dabble correction: add 3 to every scratch nibble that is 5 or more.
  always_comb begin
    w_adj = r_scr;
    for (int k = 0; k < NUM_DIGITS + 1; k++) begin
      if (r_scr[k*4 +: 4] >= 4'd5) w_adj[k*4 +: 4] = r_scr[k*4 +: 4] + 4'd3;
    end
  end

  // Conversion FSM: capture, shift DATA_W times, then commit to the display register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      r_bin      <= '0;
      r_cap      <= '0;
      r_scr      <= '0;
      r_cnt      <= '0;
      r_disp     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_bin   <= value;
            r_cap   <= value;
            r_scr   <= '0;
            r_cnt   <= CNT_W'(DATA_W);
            r_busy  <= 1'b1;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          if (load) begin
            r_pend     <= 1'b1;
            r_pend_val <= value;
          end
          r_scr <= {w_adj[SCR_W-2:0], r_bin[DATA_W-1]};
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          r_disp <= r_scr[DSP_W-1:0];
          r_ovf  <= (64'(r_cap) >= LIMIT);
          if (w_next_go) begin
            r_bin   <= w_next_val;
            r_cap   <= w_next_val;
            r_scr   <= '0;
            r_cnt   <= CNT_W'(DATA_W);
            r_pend  <= 1'b0;
            r_state <= S_CONV;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Refresh timer: hold each digit for REFRESH_DIV cycles, then step to the next digit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ref <= '0;
      r_idx <= '0;
    end else if (r_ref == REF_W'(REFRESH_DIV - 1)) begin
      r_ref <= '0;
      r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_ref <= r_ref + REF_W'(1);
    end
  end

`ifdef SSD_BLANK_EN
  logic w_seen;
  // Blank every digit above the most significant nonzero one; digit 0 always stays lit.
  always_comb begin
    w_blank = '0;
    w_seen  = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (r_disp[k*4 +: 4] != 4'd0) w_seen = 1'b1;
      w_blank[k] = ~w_seen;
    end
  end
`else
  assign w_blank = '0;
`endif

  assign w_nib       = 4'(r_disp >> {r_idx, 2'b00});
  assign w_blank_bus = w_blank >> r_idx;
  assign w_blank_sel = w_blank_bus[0];

  // Segment pattern for the selected digit: overflow beats blanking beats the BCD digit.
  always_comb begin
    if (r_ovf)            w_seg = 7'b1111110;
    else if (w_blank_sel) w_seg = 7'b1111111;
    else                  w_seg = seg_decode(w_nib);
  end

  // Registered pins so anode and segments switch on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_anode <= ~NUM_DIGITS'(1);
      r_seg   <= 7'b0000001;
    end else begin
      r_anode <= ~(NUM_DIGITS'(1) << r_idx);
      r_seg   <= w_seg;
    end
  end

  assign busy     = r_busy;
  assign overflow = r_ovf;
  assign anode    = r_anode;
  assign seg      = r_seg;

endmodule

// File: tb/tb_ssd_mux_driver.sv
// Scoreboard bench for ssd_mux_driver (4 digits, 14-bit input, refresh every 4 cycles).
module tb_ssd_mux_driver;

  localparam int ND = 4;
  localparam int DW = 14;
  localparam int RD = 4;

  localparam logic [6:0] S0 = 7'b0000001, S2 = 7'b0010010, S3 = 7'b0000110;
  localparam logic [6:0] S1 = 7'b1001111, S4 = 7'b1001100, S5 = 7'b0100100;
  localparam logic [6:0] S7 = 7'b0001111, S8 = 7'b0000000, S9 = 7'b0000100;
  localparam logic [6:0] SM = 7'b1111110, SB = 7'b1111111;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] value = '0;
  logic          load = 1'b0;
  logic          busy, overflow;
  logic [ND-1:0] anode;
  logic [6:0]    seg;

  ssd_mux_driver #(.NUM_DIGITS(ND), .DATA_W(DW), .REFRESH_DIV(RD)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .busy(busy), .overflow(overflow), .anode(anode), .seg(seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ovf;
    logic [27:0] segs;  // {d3,d2,d1,d0}
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   mon_done = 0;
  int   exp_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic ovf, input logic [6:0] d3, d2, d1, d0);
    exp_t e;
    e.ovf  = ovf;
    e.segs = {d3, d2, d1, d0};
    q.push_back(e);
  endtask

  // Watch one full refresh round and record the segments seen under each anode.
  task automatic scan(output logic [27:0] s);
    s = 'x;
    for (int c = 0; c < ND * RD; c++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++)
        if (anode == ~(4'b0001 << d)) s[d*7 +: 7] = seg;
    end
  endtask

  task automatic cmp_scan(input string tag, input logic [27:0] act, input logic [27:0] exp);
    for (int d = 0; d < ND; d++)
      chk($sformatf("%s_digit%0d", tag, d), 32'(act[d*7 +: 7]), 32'(exp[d*7 +: 7]));
  endtask

  // Monitor: a falling busy (outside reset) marks a commit; compare it with the queue head.
  initial begin
    logic        prev;
    logic [27:0] s;
    exp_t        e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (prev && !busy && !reset) begin
        if (q.size() == 0) begin
          chk("unexpected_commit", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("overflow", 32'(overflow), 32'(e.ovf));
          scan(s);
          cmp_scan("commit", s, e.segs);
        end
        mon_done++;
      end
      prev = busy;
    end
  end

  task automatic pulse_load(input logic [DW-1:0] v);
    @(negedge clk);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  // Count busy cycles; optionally issue extra loads at given busy-cycle indices.
  task automatic run_conv(input int exp_len, input int l1, input logic [DW-1:0] v1,
                          input int l2, input logic [DW-1:0] v2,
                          output bit saw5, output bit saw7);
    int n;
    n = 0; saw5 = 0; saw7 = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      n++;
      if (i >= 16 && anode == 4'b1110 && seg == S5) saw5 = 1;
      if (seg == S7) saw7 = 1;
      load = (i == l1) || (i == l2);
      if (i == l1) value = v1;
      if (i == l2) value = v2;
      @(negedge clk);
    end
    load = 1'b0;
    chk("busy_len", 32'(n), 32'(exp_len));
  endtask

  task automatic wait_mon(input int target);
    int t;
    t = 0;
    while (mon_done < target && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("monitor_done", 32'(mon_done >= target), 32'd1);
  endtask

  task automatic do_vec(input logic [DW-1:0] v);
    bit s5, s7;
    pulse_load(v);
    run_conv(DW + 1, -1, '0, -1, '0, s5, s7);
    exp_done++;
    wait_mon(exp_done);
  endtask

  initial begin
    bit          s5, s7;
    int          rec, nb;
    logic [27:0] s;

    // Reset asserted mid-refresh
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_anode", 32'(anode), 32'h0000000e);
    chk("rst_seg", 32'(seg), 32'(S0));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 4)  chk("refresh_k4",  32'(anode), 32'h0000000e);
      if (k == 5)  chk("refresh_k5",  32'(anode), 32'h0000000d);
      if (k == 9)  chk("refresh_k9",  32'(anode), 32'h0000000b);
      if (k == 13) chk("refresh_k13", 32'(anode), 32'h00000007);
      if (k == 17) chk("refresh_k17", 32'(anode), 32'h0000000e);
    end

    push_exp(1'b0, S1, S2, S3, S4);  do_vec(14'd1234);
    push_exp(1'b0, S9, S9, S9, S9);  do_vec(14'd9999);
    push_exp(1'b1, SM, SM, SM, SM);  do_vec(14'd10000);
`ifdef SSD_BLANK_EN
    push_exp(1'b0, SB, SB, S4, S2);  do_vec(14'd42);
    push_exp(1'b0, SB, SB, SB, S0);  do_vec(14'd0);
    push_exp(1'b0, SB, S3, S0, S0);
`else
    push_exp(1'b0, S0, S0, S4, S2);  do_vec(14'd42);
    push_exp(1'b0, S0, S0, S0, S0);  do_vec(14'd0);
    push_exp(1'b0, S0, S3, S0, S0);
`endif
    // 5, then 77 and 300 while busy: only 5 and 300 commit
    pulse_load(14'd5);
    run_conv(2 * (DW + 1), 1, 14'd77, 4, 14'd300, s5, s7);
    chk("pending_saw5", 32'(s5), 32'd1);
    chk("pending_no77", 32'(s7), 32'd0);
    exp_done++;
    wait_mon(exp_done);

    push_exp(1'b1, SM, SM, SM, SM);  do_vec(14'd16383);

    // Reset five cycles into converting 8191
    pulse_load(14'd8191);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    chk("midrst_anode", 32'(anode), 32'h0000000e);
    chk("midrst_seg", 32'(seg), 32'(S0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    rec = mon_done;
    scan(s);
`ifdef SSD_BLANK_EN
    cmp_scan("midrst", s, {SB, SB, SB, S0});
`else
    cmp_scan("midrst", s, {S0, S0, S0, S0});
`endif
    nb = 0;
    repeat (2 * DW) begin
      @(negedge clk);
      if (busy) nb++;
    end
    chk("no_late_busy", 32'(nb), 32'd0);
    chk("no_late_commit", 32'(mon_done), 32'(rec));

`ifdef SSD_BLANK_EN
    push_exp(1'b0, SB, SB, SB, S8);  do_vec(14'd8);
`else
    push_exp(1'b0, S0, S0, S0, S8);  do_vec(14'd8);
`endif

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
